fwd_stall_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core. Keeps a scoreboard of

---
 rtl/fwd_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_fwd_stall_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS core: E/M/W destination scoreboard, forwarding selects, D-stage stall.
// Optional MDU busy interlock is compiled in when MDU_STALL_EN is defined.
module fwd_stall_ctrl #(
   parameter int MD_MUL_CYC = 5,
   parameter int MD_DIV_CYC = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_valid,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic [4:0] d_dst,
   input  logic [1:0] d_tnew,
   input  logic       d_md_use,
   input  logic       d_md_start,
   input  logic       d_md_div,
   output logic       stall,
   output logic [1:0] sel_d_rs,
   output logic [1:0] sel_d_rt,
   output logic [1:0] sel_e_rs,
   output logic [1:0] sel_e_rt
);

   logic [4:0] e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
   logic [4:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
   logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
   logic       advance;
   logic       md_stall;
   logic [1:0] haz;
   logic [3:0] sel_d_all, sel_e_all;

   assign advance = d_valid && !stall;

   always_comb begin
      e_dst_d  = advance ? d_dst  : 5'd0;
      e_tnew_d = advance ? d_tnew : 2'd0;
      e_rs_d   = advance ? d_rs   : 5'd0;
      e_rt_d   = advance ? d_rt   : 5'd0;
      m_dst_d  = e_dst_q;
      m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      w_dst_d  = m_dst_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_dst_q  <= 5'd0;
         e_tnew_q <= 2'd0;
         e_rs_q   <= 5'd0;
         e_rt_q   <= 5'd0;
         m_dst_q  <= 5'd0;
         m_tnew_q <= 2'd0;
         w_dst_q  <= 5'd0;
      end else begin
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         w_dst_q  <= w_dst_d;
      end
   end

   // gi = 0 handles rs, gi = 1 handles rt
   for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic [4:0] src_d, src_e;
      logic [1:0] tuse;
      logic       hit_e, hit_m, hit_w, ehit_m, ehit_w;

      assign src_d  = (gi == 0) ? d_rs : d_rt;
      assign src_e  = (gi == 0) ? e_rs_q : e_rt_q;
      assign tuse   = (gi == 0) ? d_tuse_rs : d_tuse_rt;
      assign hit_e  = (src_d != 5'd0) && (e_dst_q == src_d);
      assign hit_m  = (src_d != 5'd0) && (m_dst_q == src_d);
      assign hit_w  = (src_d != 5'd0) && (w_dst_q == src_d);
      assign ehit_m = (src_e != 5'd0) && (m_dst_q == src_e);
      assign ehit_w = (src_e != 5'd0) && (w_dst_q == src_e);

      // A younger producer still computing hides older copies of the same register.
      assign sel_d_all[2*gi +: 2] = hit_e ? ((e_tnew_q == 2'd0) ? 2'd1 : 2'd0) :
                                    hit_m ? ((m_tnew_q == 2'd0) ? 2'd2 : 2'd0) :
                                    hit_w ? 2'd3 : 2'd0;
      assign sel_e_all[2*gi +: 2] = (ehit_m && (m_tnew_q == 2'd0)) ? 2'd2 :
                                    ehit_w ? 2'd3 : 2'd0;
      assign haz[gi] = (hit_e && (e_tnew_q > tuse)) || (hit_m && (m_tnew_q > tuse));
   end

`ifdef MDU_STALL_EN
   localparam int MD_MAX = (MD_DIV_CYC > MD_MUL_CYC) ? MD_DIV_CYC : MD_MUL_CYC;
   localparam int BW     = $clog2(MD_MAX + 1);

   logic [BW-1:0] busy_q, busy_d;
   logic          e_md_q, e_md_d;

   always_comb begin
      e_md_d = advance && d_md_start;
      busy_d = busy_q;
      if (advance && d_md_start) begin
         busy_d = d_md_div ? BW'(MD_DIV_CYC) : BW'(MD_MUL_CYC);
      end else if (busy_q != '0) begin
         busy_d = busy_q - BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         e_md_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         e_md_q <= e_md_d;
      end
   end

   assign md_stall = d_valid && d_md_use && ((busy_q != '0) || e_md_q);
`else
   logic unused_md;
   assign unused_md = ^{d_md_use, d_md_start, d_md_div};
   assign md_stall  = 1'b0;
`endif

   assign stall    = (d_valid && (|haz)) || md_stall;
   assign sel_d_rs = sel_d_all[1:0];
   assign sel_d_rt = sel_d_all[3:2];
   assign sel_e_rs = sel_e_all[1:0];
   assign sel_e_rt = sel_e_all[3:2];

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Self-checking bench for fwd_stall_ctrl: directed hazard scenarios plus randomized traffic
// compared with an instruction-age model. Define MDU_STALL_EN to exercise the MDU interlock.
module tb_fwd_stall_ctrl;
   localparam int MUL_CYC = 5;
   localparam int DIV_CYC = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid, d_md_use, d_md_start, d_md_div;
   logic [4:0] d_rs, d_rt, d_dst;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       stall;
   logic [1:0] sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt;

   int checks = 0;
   int failures = 0;

   fwd_stall_ctrl #(.MD_MUL_CYC(MUL_CYC), .MD_DIV_CYC(DIV_CYC)) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
      .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
      .stall(stall), .sel_d_rs(sel_d_rs), .sel_d_rt(sel_d_rt),
      .sel_e_rs(sel_e_rs), .sel_e_rt(sel_e_rt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt, input logic [4:0] dst,
                        input logic [1:0] tnew, input logic mu, input logic ms, input logic mdv);
      d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
      d_dst = dst; d_tnew = tnew; d_md_use = mu; d_md_start = ms; d_md_div = mdv;
   endtask

   task automatic bubble();
      drive(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      bubble();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bubble();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 5'd8, 5'd9, 2'd1, 2'd1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      $display("tx reset: stall=%0b sel=%0d/%0d/%0d/%0d", stall, sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
      checks++; if ({sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt} !== 8'h00) begin failures++;
         $display("FAIL reset_sels got=%h exp=00", {sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt}); end
   endtask

   task automatic test_alu_alu();
      apply_reset();
      drive(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 5'd8, 5'd3, 2'd1, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      $display("tx alu_alu D: stall=%0b sel_d_rs=%0d", stall, sel_d_rs);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", stall); end
      checks++; if (sel_d_rs !== 2'd0) begin failures++; $display("FAIL alu_sel_d_rs got=%0d exp=0", sel_d_rs); end
      @(negedge clk);
      bubble();
      #1;
      $display("tx alu_alu E: sel_e_rs=%0d", sel_e_rs);
      checks++; if (sel_e_rs !== 2'd2) begin failures++; $display("FAIL alu_sel_e_rs got=%0d exp=2", sel_e_rs); end
   endtask

   task automatic test_load_use();
      apply_reset();
      drive(1'b1, 5'd4, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 5'd9, 5'd5, 2'd1, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      $display("tx load_use 1: stall=%0b", stall);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall1 got=%0b exp=1", stall); end
      @(negedge clk);
      #1;
      $display("tx load_use 2: stall=%0b", stall);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%0b exp=0", stall); end
      @(negedge clk);
      bubble();
      #1;
      $display("tx load_use E: sel_e_rs=%0d", sel_e_rs);
      checks++; if (sel_e_rs !== 2'd3) begin failures++; $display("FAIL lu_sel_e_rs got=%0d exp=3", sel_e_rs); end
   endtask

   task automatic test_branch();
      apply_reset();
      drive(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 5'd10, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      $display("tx branch 1: stall=%0b", stall);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL br_stall1 got=%0b exp=1", stall); end
      @(negedge clk);
      #1;
      $display("tx branch 2: stall=%0b sel_d_rs=%0d", stall, sel_d_rs);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL br_stall2 got=%0b exp=0", stall); end
      checks++; if (sel_d_rs !== 2'd2) begin failures++; $display("FAIL br_sel_d_rs got=%0d exp=2", sel_d_rs); end
   endtask

   task automatic test_jal_and_zero();
      apply_reset();
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      $display("tx jal/jr: stall=%0b sel_d_rs=%0d", stall, sel_d_rs);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL jr_stall got=%0b exp=0", stall); end
      checks++; if (sel_d_rs !== 2'd1) begin failures++; $display("FAIL jr_sel_d_rs got=%0d exp=1", sel_d_rs); end
      apply_reset();
      drive(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      $display("tx zero D: stall=%0b sel=%0d/%0d", stall, sel_d_rs, sel_d_rt);
      checks++; if ({stall, sel_d_rs, sel_d_rt} !== 5'd0) begin failures++;
         $display("FAIL zero_d got=%b exp=00000", {stall, sel_d_rs, sel_d_rt}); end
      @(negedge clk);
      bubble();
      #1;
      $display("tx zero E: sel_e=%0d/%0d", sel_e_rs, sel_e_rt);
      checks++; if ({sel_e_rs, sel_e_rt} !== 4'd0) begin failures++;
         $display("FAIL zero_e got=%b exp=0000", {sel_e_rs, sel_e_rt}); end
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      drive(1'b1, 5'd4, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 5'd9, 5'd5, 2'd1, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%0b exp=1", stall); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      $display("tx reset mid-stall: stall=%0b sel_d_rs=%0d sel_e_rs=%0d", stall, sel_d_rs, sel_e_rs);
      checks++; if ({stall, sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt} !== 9'd0) begin failures++;
         $display("FAIL rst_mid_post got=%b exp=000000000", {stall, sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt}); end
   endtask

   task automatic test_mdu();
      int n;
      apply_reset();
      drive(1'b1, 5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mdu_div_stall got=%0b exp=0", stall); end
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (stall !== 1'b1) break;
         n++;
         @(negedge clk);
      end
`ifdef MDU_STALL_EN
      $display("tx mdu div->mflo: stall cycles=%0d", n);
      checks++; if (n != DIV_CYC) begin failures++; $display("FAIL mdu_stall_cycles got=%0d exp=%0d", n, DIV_CYC); end
`else
      $display("tx mdu disabled: stall cycles=%0d", n);
      checks++; if (n != 0) begin failures++; $display("FAIL mdu_off_cycles got=%0d exp=0", n); end
`endif
   endtask

   // Model: in-flight instructions indexed by age (0=E,1=M,2=W); tnew shrinks by one per stage.
   logic [4:0] md_dst [3];
   int         md_tn  [3];
   logic [4:0] me_rs, me_rt;
   bit         me_md;
   int         md_ready;
   int         cyc;

   function automatic int eff(input int age);
      if (age >= 2) return 0;
      return (md_tn[age] > age) ? md_tn[age] - age : 0;
   endfunction

   function automatic logic [1:0] exp_sel_d(input logic [4:0] r);
      if (r == 5'd0) return 2'd0;
      for (int a = 0; a < 3; a++) begin
         if (md_dst[a] == r) begin
            if (a == 2) return 2'd3;
            return (eff(a) == 0) ? 2'(a + 1) : 2'd0;
         end
      end
      return 2'd0;
   endfunction

   function automatic logic [1:0] exp_sel_e(input logic [4:0] r);
      if (r == 5'd0) return 2'd0;
      if (md_dst[1] == r && eff(1) == 0) return 2'd2;
      if (md_dst[2] == r) return 2'd3;
      return 2'd0;
   endfunction

   function automatic bit raw(input logic [4:0] r, input logic [1:0] tuse);
      if (r == 5'd0) return 1'b0;
      return (md_dst[0] == r && eff(0) > int'(tuse)) || (md_dst[1] == r && eff(1) > int'(tuse));
   endfunction

   function automatic bit exp_stall();
      bit s;
      s = d_valid && (raw(d_rs, d_tuse_rs) || raw(d_rt, d_tuse_rt));
`ifdef MDU_STALL_EN
      s = s || (d_valid && d_md_use && (cyc < md_ready || me_md));
`endif
      return s;
   endfunction

   task automatic test_random();
      bit es, adv;
      logic [1:0] e0, e1, e2, e3;
      apply_reset();
      for (int a = 0; a < 3; a++) begin md_dst[a] = 5'd0; md_tn[a] = 0; end
      me_rs = 5'd0; me_rt = 5'd0; me_md = 1'b0; md_ready = 0; cyc = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 59) == 0);
         d_valid    = ($urandom_range(0, 3) != 0);
         d_rs       = 5'($urandom_range(0, 4));
         d_rt       = 5'($urandom_range(0, 4));
         d_tuse_rs  = 2'($urandom_range(0, 3));
         d_tuse_rt  = 2'($urandom_range(0, 3));
         d_dst      = 5'($urandom_range(0, 4));
         d_tnew     = 2'($urandom_range(0, 2));
         d_md_use   = ($urandom_range(0, 3) == 0);
         d_md_start = d_md_use && ($urandom_range(0, 1) == 1);
         d_md_div   = ($urandom_range(0, 1) == 1);
         #1;
         es = exp_stall();
         e0 = exp_sel_d(d_rs); e1 = exp_sel_d(d_rt); e2 = exp_sel_e(me_rs); e3 = exp_sel_e(me_rt);
         checks++; if (stall !== es) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, stall, es); end
         checks++; if (sel_d_rs !== e0) begin failures++; $display("FAIL rnd_sel_d_rs cyc=%0d got=%0d exp=%0d", i, sel_d_rs, e0); end
         checks++; if (sel_d_rt !== e1) begin failures++; $display("FAIL rnd_sel_d_rt cyc=%0d got=%0d exp=%0d", i, sel_d_rt, e1); end
         checks++; if (sel_e_rs !== e2) begin failures++; $display("FAIL rnd_sel_e_rs cyc=%0d got=%0d exp=%0d", i, sel_e_rs, e2); end
         checks++; if (sel_e_rt !== e3) begin failures++; $display("FAIL rnd_sel_e_rt cyc=%0d got=%0d exp=%0d", i, sel_e_rt, e3); end
         adv = d_valid && !es;
         if (reset) begin
            for (int a = 0; a < 3; a++) begin md_dst[a] = 5'd0; md_tn[a] = 0; end
            me_rs = 5'd0; me_rt = 5'd0; me_md = 1'b0; md_ready = 0;
         end else begin
            md_dst[2] = md_dst[1]; md_tn[2] = md_tn[1];
            md_dst[1] = md_dst[0]; md_tn[1] = md_tn[0];
            md_dst[0] = adv ? d_dst : 5'd0;
            md_tn[0]  = adv ? int'(d_tnew) : 0;
            me_rs = adv ? d_rs : 5'd0;
            me_rt = adv ? d_rt : 5'd0;
            me_md = adv && d_md_start;
            if (adv && d_md_start) md_ready = cyc + 1 + (d_md_div ? DIV_CYC : MUL_CYC);
         end
         cyc++;
      end
      $display("tx random: %0d cycles compared", cyc);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bubble();
      test_reset();
      test_alu_alu();
      test_load_use();
      test_branch();
      test_jal_and_zero();
      test_reset_mid_stall();
      test_mdu();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
